// File: rtl/mul8_err_monitor.sv
// Error-statistics stage for 8x8 approximate multipliers: computes the exact product of each sample and accumulates SAE, WCE and the error count over a window.
// Ports: clk/rst, start/window_len, in_valid/in_ready/in_a/in_b/in_prod, busy, res_valid/res_ack, res_sum_err/res_sat/res_max_err/res_max_a/res_max_b/res_err_cnt.
module mul8_err_monitor #(
  parameter int CNT_W = 16,
  parameter int SUM_W = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] window_len,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_a,
  input  logic [7:0]       in_b,
  input  logic [15:0]      in_prod,
  output logic             busy,
  output logic             res_valid,
  input  logic             res_ack,
  output logic [SUM_W-1:0] res_sum_err,
  output logic             res_sat,
  output logic [15:0]      res_max_err,
  output logic [7:0]       res_max_a,
  output logic [7:0]       res_max_b,
  output logic [CNT_W-1:0] res_err_cnt
);

  // Accumulation width is wide enough for one full 16-bit error plus a carry,
  // even when SUM_W is narrower than the error itself.
  localparam int AW = ((SUM_W > 16) ? SUM_W : 16) + 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DRAIN,
    S_DONE
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [CNT_W-1:0] r_len;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_inc;
  logic             w_start;
  logic             w_accept;

  logic        r_v1;
  logic [7:0]  r_a1;
  logic [7:0]  r_b1;
  logic [15:0] r_p1;
  logic [15:0] w_exact;
  logic [15:0] w_err;

  logic        r_v2;
  logic [7:0]  r_a2;
  logic [7:0]  r_b2;
  logic [15:0] r_err2;

  logic [SUM_W-1:0] r_sum;
  logic             r_sat;
  logic [15:0]      r_max;
  logic [7:0]       r_max_a;
  logic [7:0]       r_max_b;
  logic [CNT_W-1:0] r_err_cnt;
  logic [AW-1:0]    w_sum_ext;
  logic             w_ovf;

  assign w_start   = start && (r_state == S_IDLE);
  assign w_accept  = in_valid && in_ready;
  assign w_cnt_inc = r_cnt + 1'b1;

  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    res_valid = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (start)
          w_next = (window_len == '0) ? S_DONE : S_RUN;
      end
      S_RUN: begin
        busy     = 1'b1;
        in_ready = (r_cnt < r_len);
        if (w_accept && (w_cnt_inc == r_len))
          w_next = S_DRAIN;
      end
      S_DRAIN: begin
        busy = 1'b1;
        if (!r_v1 && !r_v2)
          w_next = S_DONE;
      end
      S_DONE: begin
        res_valid = 1'b1;
        if (res_ack)
          w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_len   <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_next;
      if (w_start) begin
        r_len <= window_len;
        r_cnt <= '0;
      end else if (w_accept) begin
        r_cnt <= w_cnt_inc;
      end
    end
  end

  assign w_exact = {8'd0, r_a1} * {8'd0, r_b1};
  assign w_err   = (r_p1 >= w_exact) ? (r_p1 - w_exact) : (w_exact - r_p1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1   <= 1'b0;
      r_a1   <= '0;
      r_b1   <= '0;
      r_p1   <= '0;
      r_v2   <= 1'b0;
      r_a2   <= '0;
      r_b2   <= '0;
      r_err2 <= '0;
    end else begin
      r_v1 <= w_accept;
      if (w_accept) begin
        r_a1 <= in_a;
        r_b1 <= in_b;
        r_p1 <= in_prod;
      end
      r_v2 <= r_v1;
      if (r_v1) begin
        r_a2   <= r_a1;
        r_b2   <= r_b1;
        r_err2 <= w_err;
      end
    end
  end

  assign w_sum_ext = AW'(r_sum) + AW'(r_err2);
  assign w_ovf     = |(w_sum_ext >> SUM_W);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sum     <= '0;
      r_sat     <= 1'b0;
      r_max     <= '0;
      r_max_a   <= '0;
      r_max_b   <= '0;
      r_err_cnt <= '0;
    end else if (w_start) begin
      r_sum     <= '0;
      r_sat     <= 1'b0;
      r_max     <= '0;
      r_max_a   <= '0;
      r_max_b   <= '0;
      r_err_cnt <= '0;
    end else if (r_v2) begin
      r_sum <= w_ovf ? '1 : w_sum_ext[SUM_W-1:0];
      r_sat <= r_sat | w_ovf;
      // strict compare: ties keep the operands of the earliest sample
      if (r_err2 > r_max) begin
        r_max   <= r_err2;
        r_max_a <= r_a2;
        r_max_b <= r_b2;
      end
      if (r_err2 != 16'd0)
        r_err_cnt <= r_err_cnt + 1'b1;
    end
  end

  assign res_sum_err = r_sum;
  assign res_sat     = r_sat;
  assign res_max_err = r_max;
  assign res_max_a   = r_max_a;
  assign res_max_b   = r_max_b;
  assign res_err_cnt = r_err_cnt;

endmodule
